ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage ARM pipeline; consumes everything the ID/EX pipeline register drives.
- Generates Val2 from the shifter operand, immediate or Rm; runs the ALU; computes the branch target.
- Owns the architectural NZCV status register, which it feeds back to the ID stage.
- Registers its results into the EX/MEM boundary, with freeze support for memory stalls.

Parameters:
- WORD_WIDTH, 32, datapath width (`WORD_WIDTH).
- REG_FILE_DEPTH, 4, register index width (`REG_FILE_DEPTH).
- SIGNED_IMM_WIDTH, 24, branch offset width (`SIGNED_IMM_WIDTH).
- SHIFTER_OPERAND_WIDTH, 12, shifter operand width (`SHIFTER_OPERAND_WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hold EX/MEM outputs and the status register.
- pc_in  in  32  PC+4 of the instruction.
- val_Rn_in, val_Rm_in  in  32 each  register operands.
- signed_immediate_in  in  24  branch offset.
- shifter_operand_in  in  12  operand-2 field.
- EX_command_in  in  4  ALU opcode.
- status_register_in  in  4  NZCV snapshot taken at decode.
- mem_read_in, mem_write_in, WB_en_in, Imm_in, B_in, SR_update_in  in  1 each  control bits.
- reg_file_dst_in  in  4  destination register.
- sel_src1, sel_src2  in  2 each  forwarding selects: 00 register, 01 MEM, 10 WB.
- mem_fwd_val, wb_fwd_val  in  32 each  forwarded values.
- branch_taken  out  1  combinational, equals B_in.
- branch_addr  out  32  combinational target.
- status_out  out  4  NZCV register.
- alu_result_out  out  32  registered ALU result.
- store_val_out  out  32  registered store data (forwarded Rm).
- dst_out  out  4  registered destination.
- mem_read_out, mem_write_out, WB_en_out  out  1 each  registered control bits.

Behaviour:
- Reset: rst low asynchronously clears every registered output and status_out to 0.
- Latency: one cycle from inputs to registered outputs.
- Forwarded operands:
  - opA = mux(sel_src1: val_Rn_in, mem_fwd_val, wb_fwd_val).
  - opB = same mux on sel_src2 with val_Rm_in.
  - sel value 11 selects the register value.
- Val2 generation, by priority:
  1. Imm_in=1: zero-extended shifter[7:0] rotated right by 2*shifter[11:8].
  2. mem_read_in|mem_write_in: zero-extended shifter[11:0].
  3. Otherwise: opB shifted by shifter[11:7]. shifter[6:5] selects 00 LSL, 01 LSR, 10 ASR, 11 ROR. An amount of 0 passes opB unchanged.
- ALU opcodes (C_in = status_register_in[1]):
  - 0001 MOV = Val2; 1001 MVN = ~Val2.
  - 0010 ADD = opA+Val2; 0011 ADC = +C_in.
  - 0100 SUB = opA-Val2; 0101 SBC = -!C_in.
  - 0110 AND; 0111 ORR; 1000 EOR.
  - Any other code returns 0 with flags unchanged.
- Flags:
  - N = result[31]; Z = (result==0).
  - Add ops: C = carry-out of the 33-bit sum; V = signed overflow.
  - Sub ops: C = NOT borrow; V = signed overflow.
  - Logic and move ops: C and V keep the status_register_in values.
- Status register:
  - Loads the new NZCV on a rising edge when SR_update_in=1 and freeze=0.
  - Otherwise holds.
  - The flags are never written when B_in=1.
- Branch: branch_addr = pc_in + (sign-extend(signed_immediate_in) << 2), mod 2^32. branch_taken = B_in.
- freeze=1: all registered outputs and the status register hold their values. Branch outputs remain combinational.
- Reset asserted mid-freeze: reset wins.
- Store data: store_val_out = opB, the forwarded Rm.

Optional Feature:
- Macro: EX_FORWARDING_EN.
- Defined: the forwarding muxes operate as specified above.
- Undefined:
  - sel_src1, sel_src2, mem_fwd_val and wb_fwd_val are ignored.
  - opA = val_Rn_in; opB = val_Rm_in.
  - The ports remain present so the top level is unchanged.

Decomposition:
- Shared package / settings.h holds:
  - the width macros;
  - EX_command encodings (EXE_MOV … EXE_EOR);
  - shift-type codes;
  - forwarding-select codes.
- One natural sub-module: val2_generator, which is combinational and produces Val2 from opB, the shifter operand, Imm_in and the mem flag.

Test Plan:
1. ADD overflow: opA=0x7FFFFFFF, Imm=1, shifter=0x001, SR_update=1 → alu_result=0x80000000; status=1001 (N=1, V=1) next cycle.
2. Immediate rotate: MOV, Imm=1, shifter=0x4FF → Val2=0xFF000000; N=1, Z=0.
3. Register shift: Rm=0x80000000, shifter=0x0C4 (ASR #1) → 0xC0000000. The same input with LSR → 0x40000000.
4. Branch: pc_in=0x100, imm=0xFFFFFE → branch_addr=0x0F8, branch_taken=1; status unchanged.
5. Freeze: freeze=1 for 3 cycles while the inputs change → registered outputs and status_out stay constant. Deassert freeze → new values appear one cycle later.
6. Forwarding:
   - sel_src1=01, mem_fwd_val=5, ADD Val2=3 → 8.
   - With EX_FORWARDING_EN undefined, val_Rn_in=1 is used instead → 4.
   - Reset asserted mid-test → all outputs 0 immediately.

Source files
------------

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_pkg
//  Description : Shared widths, ALU command encodings, shift-type codes and
//                forwarding-select codes for the ARM execute stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

    localparam int WORD_WIDTH            = 32;
    localparam int REG_FILE_DEPTH        = 4;
    localparam int SIGNED_IMM_WIDTH      = 24;
    localparam int SHIFTER_OPERAND_WIDTH = 12;

    // ALU command encodings driven by the decoder
    typedef enum logic [3:0] {
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    // Register-operand shift types taken from shifter_operand[6:5]
    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_type_e;

    // Forwarding mux selects; the unused code falls back to the register
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

endpackage : ex_stage_pkg
`default_nettype wire

// File: rtl/ex_stage_val2_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_val2_gen
//  Description : Combinational second-operand (Val2) generator: rotated
//                8-bit immediate, 12-bit memory offset, or shifted Rm.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_val2_gen
    import ex_stage_pkg::*;
(
    input  logic [WORD_WIDTH-1:0]            op_b_i,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_i,
    input  logic                             imm_i,
    input  logic                             mem_en_i,
    output logic [WORD_WIDTH-1:0]            val2_o
);

    logic [WORD_WIDTH-1:0]   imm_word;
    logic [4:0]              imm_rot;
    logic [2*WORD_WIDTH-1:0] imm_rot_dbl;
    logic [4:0]              sh_amt;
    logic [2*WORD_WIDTH-1:0] ror_dbl;
    logic [WORD_WIDTH-1:0]   shifted;

    assign imm_word = {{(WORD_WIDTH-8){1'b0}}, shifter_operand_i[7:0]};
    assign imm_rot  = {shifter_operand_i[11:8], 1'b0};
    assign sh_amt   = shifter_operand_i[11:7];

    // Rotations done by shifting a doubled word; a zero amount leaves the value intact
    assign imm_rot_dbl = {imm_word, imm_word} >> imm_rot;
    assign ror_dbl     = {op_b_i, op_b_i} >> sh_amt;

    // Register-operand shifter
    always_comb begin
        shifted = op_b_i;
        case (shift_type_e'(shifter_operand_i[6:5]))
            SH_LSL:  shifted = op_b_i << sh_amt;
            SH_LSR:  shifted = op_b_i >> sh_amt;
            SH_ASR:  shifted = $signed(op_b_i) >>> sh_amt;
            SH_ROR:  shifted = ror_dbl[WORD_WIDTH-1:0];
            default: shifted = op_b_i;
        endcase
    end

    // Operand source priority: immediate, then memory offset, then shifted register
    always_comb begin
        val2_o = shifted;
        if (imm_i) begin
            val2_o = imm_rot_dbl[WORD_WIDTH-1:0];
        end else if (mem_en_i) begin
            val2_o = {{(WORD_WIDTH-SHIFTER_OPERAND_WIDTH){1'b0}}, shifter_operand_i};
        end
    end

endmodule : ex_stage_val2_gen
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of the 5-stage ARM pipeline. Forwarding muxes,
//                Val2 generation, ALU, branch target, NZCV status register
//                and the EX/MEM pipeline register with freeze.
//  Config      : `define EX_FORWARDING_EN enables the operand forwarding muxes;
//                otherwise the register operands are used directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             freeze,
    input  logic [WORD_WIDTH-1:0]            pc_in,
    input  logic [WORD_WIDTH-1:0]            val_Rn_in,
    input  logic [WORD_WIDTH-1:0]            val_Rm_in,
    input  logic [SIGNED_IMM_WIDTH-1:0]      signed_immediate_in,
    input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
    input  logic [3:0]                       EX_command_in,
    input  logic [3:0]                       status_register_in,
    input  logic                             mem_read_in,
    input  logic                             mem_write_in,
    input  logic                             WB_en_in,
    input  logic                             Imm_in,
    input  logic                             B_in,
    input  logic                             SR_update_in,
    input  logic [REG_FILE_DEPTH-1:0]        reg_file_dst_in,
    input  logic [1:0]                       sel_src1,
    input  logic [1:0]                       sel_src2,
    input  logic [WORD_WIDTH-1:0]            mem_fwd_val,
    input  logic [WORD_WIDTH-1:0]            wb_fwd_val,
    output logic                             branch_taken,
    output logic [WORD_WIDTH-1:0]            branch_addr,
    output logic [3:0]                       status_out,
    output logic [WORD_WIDTH-1:0]            alu_result_out,
    output logic [WORD_WIDTH-1:0]            store_val_out,
    output logic [REG_FILE_DEPTH-1:0]        dst_out,
    output logic                             mem_read_out,
    output logic                             mem_write_out,
    output logic                             WB_en_out
);

    logic [WORD_WIDTH-1:0] op_a;
    logic [WORD_WIDTH-1:0] op_b;
    logic [WORD_WIDTH-1:0] val2;
    logic [WORD_WIDTH-1:0] alu_res_d;
    logic [3:0]            nzcv_d;
    logic                  c_in;

    logic [WORD_WIDTH-1:0]     alu_result_q;
    logic [WORD_WIDTH-1:0]     store_val_q;
    logic [REG_FILE_DEPTH-1:0] dst_q;
    logic                      mem_read_q;
    logic                      mem_write_q;
    logic                      wb_en_q;
    logic [3:0]                status_q;

`ifdef EX_FORWARDING_EN
    // Operand forwarding from the MEM and WB stages
    always_comb begin
        op_a = val_Rn_in;
        op_b = val_Rm_in;
        case (fwd_sel_e'(sel_src1))
            FWD_MEM: op_a = mem_fwd_val;
            FWD_WB:  op_a = wb_fwd_val;
            default: op_a = val_Rn_in;
        endcase
        case (fwd_sel_e'(sel_src2))
            FWD_MEM: op_b = mem_fwd_val;
            FWD_WB:  op_b = wb_fwd_val;
            default: op_b = val_Rm_in;
        endcase
    end
`else
    // Forwarding ports stay on the boundary but are not consumed
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, mem_fwd_val, wb_fwd_val};
    assign op_a       = val_Rn_in;
    assign op_b       = val_Rm_in;
`endif

    ex_stage_val2_gen u_val2_gen (
        .op_b_i            (op_b),
        .shifter_operand_i (shifter_operand_in),
        .imm_i             (Imm_in),
        .mem_en_i          (mem_read_in | mem_write_in),
        .val2_o            (val2)
    );

    assign c_in = status_register_in[1];

    // ALU and NZCV generation; unknown commands yield 0 and keep the decode-time flags
    always_comb begin
        logic [WORD_WIDTH:0] sum;
        logic                c_new;
        logic                v_new;
        logic                known;
        sum       = '0;
        alu_res_d = '0;
        c_new     = status_register_in[1];
        v_new     = status_register_in[0];
        known     = 1'b1;
        case (exe_cmd_e'(EX_command_in))
            EXE_MOV: alu_res_d = val2;
            EXE_MVN: alu_res_d = ~val2;
            EXE_ADD, EXE_ADC: begin
                sum = {1'b0, op_a} + {1'b0, val2}
                    + {{WORD_WIDTH{1'b0}}, (EX_command_in == EXE_ADC) & c_in};
                alu_res_d = sum[WORD_WIDTH-1:0];
                c_new     = sum[WORD_WIDTH];
                v_new     = (op_a[WORD_WIDTH-1] == val2[WORD_WIDTH-1]) &&
                            (alu_res_d[WORD_WIDTH-1] != op_a[WORD_WIDTH-1]);
            end
            EXE_SUB, EXE_SBC: begin
                sum = {1'b0, op_a} - {1'b0, val2}
                    - {{WORD_WIDTH{1'b0}}, (EX_command_in == EXE_SBC) & ~c_in};
                alu_res_d = sum[WORD_WIDTH-1:0];
                c_new     = ~sum[WORD_WIDTH];
                v_new     = (op_a[WORD_WIDTH-1] != val2[WORD_WIDTH-1]) &&
                            (alu_res_d[WORD_WIDTH-1] != op_a[WORD_WIDTH-1]);
            end
            EXE_AND: alu_res_d = op_a & val2;
            EXE_ORR: alu_res_d = op_a | val2;
            EXE_EOR: alu_res_d = op_a ^ val2;
            default: known = 1'b0;
        endcase
        nzcv_d = known ? {alu_res_d[WORD_WIDTH-1], alu_res_d == '0, c_new, v_new}
                       : status_register_in;
    end

    // Branch target: PC+4 plus word-scaled signed offset
    assign branch_addr  = pc_in + {{(WORD_WIDTH-SIGNED_IMM_WIDTH-2){signed_immediate_in[SIGNED_IMM_WIDTH-1]}},
                                   signed_immediate_in, 2'b00};
    assign branch_taken = B_in;

    // EX/MEM pipeline register, held while frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_q <= '0;
            store_val_q  <= '0;
            dst_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            wb_en_q      <= 1'b0;
        end else if (!freeze) begin
            alu_result_q <= alu_res_d;
            store_val_q  <= op_b;
            dst_q        <= reg_file_dst_in;
            mem_read_q   <= mem_read_in;
            mem_write_q  <= mem_write_in;
            wb_en_q      <= WB_en_in;
        end
    end

    // Architectural status register; branches never write the flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= '0;
        end else if (!freeze && SR_update_in && !B_in) begin
            status_q <= nzcv_d;
        end
    end

    assign alu_result_out = alu_result_q;
    assign store_val_out  = store_val_q;
    assign dst_out        = dst_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign WB_en_out      = wb_en_q;
    assign status_out     = status_q;

endmodule : ex_stage
`default_nettype wire
